// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Multicycle RISC-V fetch stage; owns the PC, issues single
//                outstanding word reads and holds the fetched instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] c_FETCH = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_HOLD  = 2'd2;
    localparam logic [1:0] c_DRAIN = 2'd3;
    localparam logic [31:0] c_WORD_MASK = 32'hFFFF_FFFC;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_instr_valid;
    logic [31:0] r_fetch_count;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_instr_pc_nxt;
    logic        w_instr_valid_nxt;
    logic [31:0] w_fetch_count_nxt;
    logic [31:0] w_redirect_pc;

    assign w_redirect_pc = redirect_pc & c_WORD_MASK;

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_instr_nxt       = r_instr;
        w_instr_pc_nxt    = r_instr_pc;
        w_instr_valid_nxt = r_instr_valid;
        w_fetch_count_nxt = r_fetch_count;

        case (r_state)
            c_FETCH: begin
                // The request at the old pc goes out regardless; a redirect
                // only decides whether its response will be kept.
                if (redirect_valid) begin
                    w_pc_nxt    = w_redirect_pc;
                    w_state_nxt = c_DRAIN;
                end else begin
                    w_state_nxt = c_WAIT;
                end
            end
            c_WAIT: begin
                if (redirect_valid) begin
                    w_pc_nxt    = w_redirect_pc;
                    w_state_nxt = mem_rvalid ? c_FETCH : c_DRAIN;
                end else if (mem_rvalid) begin
                    w_instr_nxt       = mem_rdata;
                    w_instr_pc_nxt    = r_pc;
                    w_pc_nxt          = r_pc + 32'd4;
                    w_instr_valid_nxt = 1'b1;
                    w_state_nxt       = c_HOLD;
                end
            end
            c_HOLD: begin
                if (redirect_valid) begin
                    w_pc_nxt          = w_redirect_pc;
                    w_instr_valid_nxt = 1'b0;
                    w_instr_nxt       = NOP_INSTR;
                    w_state_nxt       = c_FETCH;
                end else if (instr_ready) begin
                    w_instr_valid_nxt = 1'b0;
                    w_fetch_count_nxt = r_fetch_count + 32'd1;
                    w_state_nxt       = c_FETCH;
                end
            end
            c_DRAIN: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redirect_pc;
                end
                if (mem_rvalid) begin
                    w_state_nxt = c_FETCH;
                end
            end
            default: begin
                w_state_nxt = c_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_FETCH;
            r_pc          <= RESET_PC & c_WORD_MASK;
            r_instr       <= NOP_INSTR;
            r_instr_pc    <= 32'd0;
            r_instr_valid <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

    // Request is suppressed while reset is held even though the state is FETCH.
    assign mem_req     = rst_n && (r_state == c_FETCH);
    assign mem_addr    = r_pc & c_WORD_MASK;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire
